// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds the FSM encoding, the port indices and the full-word byte mask.
package dmem_arb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_e;

  localparam logic P_CORE = 1'b0;
  localparam logic P_DBG  = 1'b1;

  localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/dmem_arbiter_byte_merge.sv
// Four-lane byte select: each lane takes the new byte when its enable is set.
// Kept standalone so the load/store unit can share it.
module byte_merge (
  input  logic [31:0] old_i,
  input  logic [31:0] new_i,
  input  logic [3:0]  be_i,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = old_i;
    for (int i = 0; i < 4; i++) begin
      if (be_i[i]) merged_o[8*i +: 8] = new_i[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for two requesters in front of a single-port word memory.
// Partial stores become a two-cycle read-modify-write; everything else finishes in one.
//
// state  | meaning
// IDLE   | arbitrate; loads, full/empty stores and out-of-range accesses finish here
// RMW_WR | write back the merged word latched in IDLE and grant its owner
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          REQ0,
  input  logic          REQ1,
  input  logic          WR0,
  input  logic          WR1,
  input  logic [AW-1:0] ADDR0,
  input  logic [AW-1:0] ADDR1,
  input  logic [31:0]   WDATA0,
  input  logic [31:0]   WDATA1,
  input  logic [3:0]    BE0,
  input  logic [3:0]    BE1,
  output logic          GNT0,
  output logic          GNT1,
  output logic          RVALID0,
  output logic          RVALID1,
  output logic [31:0]   RDATA,
  output logic          ERR,
  output logic [AW-1:0] M_A,
  output logic [31:0]   M_WD,
  output logic          M_WE,
  input  logic [31:0]   M_RD
);

  localparam logic [AW-3:0] DEPTH_W = (AW-2)'(DEPTH);

  state_e        state_q, state_d;
  logic          last_q;
  logic          owner_q;
  logic [AW-3:0] waddr_q;
  logic [31:0]   merged_q;
  logic [31:0]   rdata_q;
  logic          rvalid0_q, rvalid1_q, err_q;

  logic          sel_req, sel_port, sel_wr, sel_in_range, sel_partial;
  logic [AW-1:0] sel_addr;
  logic [31:0]   sel_wdata, merged_w;
  logic [3:0]    sel_be;
  logic          gnt0, gnt1, idle_load;

  // Round-robin: under contention the port not granted last wins.
  always_comb begin
    sel_req = REQ0 | REQ1;
    if (REQ0 && REQ1) sel_port = ~last_q;
    else              sel_port = REQ1 ? P_DBG : P_CORE;
    sel_wr    = (sel_port == P_DBG) ? WR1    : WR0;
    sel_addr  = (sel_port == P_DBG) ? ADDR1  : ADDR0;
    sel_wdata = (sel_port == P_DBG) ? WDATA1 : WDATA0;
    sel_be    = (sel_port == P_DBG) ? BE1    : BE0;
  end

  assign sel_in_range = (sel_addr[AW-1:2] < DEPTH_W);
  assign sel_partial  = sel_wr && sel_in_range && (sel_be != BE_FULL) && (sel_be != 4'h0);
  assign idle_load    = (state_q == IDLE) && !sel_wr;

  byte_merge u_merge (
    .old_i    (M_RD),
    .new_i    (sel_wdata),
    .be_i     (sel_be),
    .merged_o (merged_w)
  );

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (sel_req && sel_partial) state_d = RMW_WR;
      RMW_WR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    M_A  = '0;
    M_WD = '0;
    M_WE = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sel_req) begin
          M_A = sel_addr;
          if (!sel_partial) begin
            gnt0 = (sel_port == P_CORE);
            gnt1 = (sel_port == P_DBG);
            if (sel_wr && sel_in_range && (sel_be == BE_FULL)) begin
              M_WE = 1'b1;
              M_WD = sel_wdata;
            end
          end
        end
      end
      RMW_WR: begin
        M_A  = {waddr_q, 2'b00};
        M_WD = merged_q;
        M_WE = 1'b1;
        gnt0 = (owner_q == P_CORE);
        gnt1 = (owner_q == P_DBG);
      end
      default: ;
    endcase
    // A reset landing mid-RMW must not commit the half-finished store.
    if (RST) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      M_WE = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_q    <= 1'b1;
      owner_q   <= P_CORE;
      waddr_q   <= '0;
      merged_q  <= '0;
      rdata_q   <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rvalid0_q <= gnt0 && idle_load;
      rvalid1_q <= gnt1 && idle_load;
      err_q     <= (gnt0 || gnt1) && (state_q == IDLE) && !sel_in_range;
      if ((gnt0 || gnt1) && idle_load) rdata_q <= sel_in_range ? M_RD : '0;
      if (gnt0 || gnt1) last_q <= gnt1;
      if ((state_q == IDLE) && (state_d == RMW_WR)) begin
        merged_q <= merged_w;
        waddr_q  <= sel_addr[AW-1:2];
        owner_q  <= sel_port;
      end
    end
  end

  assign GNT0    = gnt0;
  assign GNT1    = gnt1;
  assign RVALID0 = rvalid0_q;
  assign RVALID1 = rvalid1_q;
  assign RDATA   = rdata_q;
  assign ERR     = err_q;

  a_req0_held: assert property (@(posedge CLK) (REQ0 && !GNT0 && !RST) |=> (REQ0 || RST));
  a_req1_held: assert property (@(posedge CLK) (REQ1 && !GNT1 && !RST) |=> (REQ1 || RST));
  a_gnt_excl:  assert property (@(posedge CLK) !(GNT0 && GNT1));
  a_rv_excl:   assert property (@(posedge CLK) !(RVALID0 && RVALID1));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural word memory.
// Expected load data is queued per port at grant time and popped on RVALID.
module tb_dmem_arbiter;
  localparam int DEPTH = 64;
  localparam int AW    = 32;

  logic          CLK = 1'b0;
  logic          RST;
  logic          REQ0, REQ1, WR0, WR1;
  logic [AW-1:0] ADDR0, ADDR1;
  logic [31:0]   WDATA0, WDATA1;
  logic [3:0]    BE0, BE1;
  logic          GNT0, GNT1, RVALID0, RVALID1, ERR, M_WE;
  logic [31:0]   RDATA, M_WD, M_RD;
  logic [AW-1:0] M_A;

  logic [31:0] mem [DEPTH];
  logic        bd_we = 1'b0;
  logic [5:0]  bd_idx = '0;
  logic [31:0] bd_data = '0;

  int errors = 0;
  int checks = 0;
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] exp_d;

  dmem_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .REQ1(REQ1), .WR0(WR0), .WR1(WR1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .BE0(BE0), .BE1(BE1), .GNT0(GNT0), .GNT1(GNT1),
    .RVALID0(RVALID0), .RVALID1(RVALID1), .RDATA(RDATA), .ERR(ERR),
    .M_A(M_A), .M_WD(M_WD), .M_WE(M_WE), .M_RD(M_RD)
  );

  always #5 CLK = ~CLK;

  assign M_RD = (M_A[AW-1:8] == '0) ? mem[M_A[7:2]] : 32'h0;

  always @(posedge CLK) begin
    if (M_WE && (M_A[AW-1:8] == '0)) mem[M_A[7:2]] <= M_WD;
    if (bd_we) mem[bd_idx] <= bd_data;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive0(input logic req, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be);
    REQ0 = req; WR0 = wr; ADDR0 = addr; WDATA0 = wd; BE0 = be;
  endtask

  task automatic drive1(input logic req, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be);
    REQ1 = req; WR1 = wr; ADDR1 = addr; WDATA1 = wd; BE1 = be;
  endtask

  task automatic preload(input int idx, input logic [31:0] d);
    bd_we = 1'b1; bd_idx = idx[5:0]; bd_data = d;
    step();
    bd_we = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    drive0(0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0);
    step();
    preload(8,  32'h11223344);
    preload(16, 32'hCAFEF00D);
    preload(1,  32'hA0A0A0A0);
    preload(2,  32'hB0B0B0B0);
    preload(63, 32'h12345678);
    preload(12, 32'h55667788);
    preload(4,  32'h00000000);
    RST = 1'b0;
    @(negedge CLK);
    checks++; if ({GNT0, GNT1} !== 2'b00) begin errors++; $display("FAIL rst_gnt: got %b want 00", {GNT0, GNT1}); end
    checks++; if (M_WE !== 1'b0) begin errors++; $display("FAIL rst_m_we: got %b want 0", M_WE); end
    checks++; if (M_A !== 32'h0) begin errors++; $display("FAIL rst_m_a: got %h want 0", M_A); end
    checks++; if (M_WD !== 32'h0) begin errors++; $display("FAIL rst_m_wd: got %h want 0", M_WD); end
    checks++; if ({RVALID0, RVALID1, ERR} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b want 000", {RVALID0, RVALID1, ERR}); end
    checks++; if (RDATA !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", RDATA); end
    step();
  endtask

  task automatic test_full_store_load();
    drive0(1, 1, 32'h10, 32'hDEADBEEF, 4'hF);
    @(negedge CLK);
    checks++; if ({GNT0, GNT1, M_WE} !== 3'b101) begin errors++; $display("FAIL st_gnt_we: got %b want 101", {GNT0, GNT1, M_WE}); end
    checks++; if (M_A !== 32'h10 || M_WD !== 32'hDEADBEEF) begin errors++; $display("FAIL st_bus: got a=%h wd=%h want a=10 wd=deadbeef", M_A, M_WD); end
    step();
    drive0(1, 0, 32'h10, 0, 0);
    q0.push_back(32'hDEADBEEF);
    @(negedge CLK);
    checks++; if ({GNT0, M_WE} !== 2'b10) begin errors++; $display("FAIL ld_gnt: got %b want 10", {GNT0, M_WE}); end
    checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL st_mem: got %h want deadbeef", mem[4]); end
    step();
    drive0(0, 0, 0, 0, 0);
    @(negedge CLK);
    exp_d = (q0.size() > 0) ? q0.pop_front() : 32'hxxxxxxxx;
    checks++; if ({RVALID0, RVALID1} !== 2'b10) begin errors++; $display("FAIL ld_rvalid: got %b want 10", {RVALID0, RVALID1}); end
    checks++; if (RDATA !== exp_d) begin errors++; $display("FAIL ld_rdata: got %h want %h", RDATA, exp_d); end
    step();
  endtask

  task automatic test_rmw();
    drive1(1, 1, 32'h20, 32'h000000AA, 4'b0001);
    @(negedge CLK);
    checks++; if ({GNT0, GNT1, M_WE} !== 3'b000) begin errors++; $display("FAIL rmw_c1: got %b want 000", {GNT0, GNT1, M_WE}); end
    step();
    @(negedge CLK);
    checks++; if ({GNT0, GNT1, M_WE} !== 3'b011) begin errors++; $display("FAIL rmw_c2: got %b want 011", {GNT0, GNT1, M_WE}); end
    checks++; if (M_A !== 32'h20 || M_WD !== 32'h112233AA) begin errors++; $display("FAIL rmw_bus: got a=%h wd=%h want a=20 wd=112233aa", M_A, M_WD); end
    step();
    drive1(0, 0, 0, 0, 0);
    @(negedge CLK);
    checks++; if (mem[8] !== 32'h112233AA) begin errors++; $display("FAIL rmw_mem: got %h want 112233aa", mem[8]); end
    checks++; if (RVALID1 !== 1'b0) begin errors++; $display("FAIL rmw_rvalid: got %b want 0", RVALID1); end
    step();
  endtask

  task automatic test_rmw_contention();
    drive0(1, 1, 32'h40, 32'h00001200, 4'b0010);
    drive1(1, 0, 32'h40, 0, 0);
    @(negedge CLK);
    checks++; if ({GNT0, GNT1, M_WE} !== 3'b000) begin errors++; $display("FAIL rmwc_c1: got %b want 000", {GNT0, GNT1, M_WE}); end
    step();
    @(negedge CLK);
    checks++; if ({GNT0, GNT1, M_WE} !== 3'b101) begin errors++; $display("FAIL rmwc_c2: got %b want 101", {GNT0, GNT1, M_WE}); end
    checks++; if (M_WD !== 32'hCAFE120D) begin errors++; $display("FAIL rmwc_wd: got %h want cafe120d", M_WD); end
    step();
    drive0(0, 0, 0, 0, 0);
    q1.push_back(32'hCAFE120D);
    @(negedge CLK);
    checks++; if ({GNT0, GNT1} !== 2'b01) begin errors++; $display("FAIL rmwc_gnt1: got %b want 01", {GNT0, GNT1}); end
    step();
    drive1(0, 0, 0, 0, 0);
    @(negedge CLK);
    exp_d = (q1.size() > 0) ? q1.pop_front() : 32'hxxxxxxxx;
    checks++; if ({RVALID0, RVALID1} !== 2'b01) begin errors++; $display("FAIL rmwc_rvalid: got %b want 01", {RVALID0, RVALID1}); end
    checks++; if (RDATA !== exp_d) begin errors++; $display("FAIL rmwc_rdata: got %h want %h", RDATA, exp_d); end
    step();
  endtask

  task automatic test_contention();
    int prev;
    RST = 1'b1;
    step();
    RST = 1'b0;
    drive0(1, 0, 32'h4, 0, 0);
    drive1(1, 0, 32'h8, 0, 0);
    for (int k = 0; k < 7; k++) begin
      if (k == 6) drive1(0, 0, 0, 0, 0);
      @(negedge CLK);
      if (k > 0) begin
        prev = (k - 1) % 2;
        if (prev == 0) exp_d = (q0.size() > 0) ? q0.pop_front() : 32'hxxxxxxxx;
        else           exp_d = (q1.size() > 0) ? q1.pop_front() : 32'hxxxxxxxx;
        checks++; if ({RVALID0, RVALID1} !== ((prev == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_rvalid k=%0d: got %b want port %0d", k, {RVALID0, RVALID1}, prev); end
        checks++; if (RDATA !== exp_d) begin errors++; $display("FAIL rr_rdata k=%0d: got %h want %h", k, RDATA, exp_d); end
      end
      checks++; if ({GNT0, GNT1} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_gnt k=%0d: got %b want port %0d", k, {GNT0, GNT1}, k % 2); end
      if (k % 2 == 0) q0.push_back(32'hA0A0A0A0);
      else            q1.push_back(32'hB0B0B0B0);
      step();
    end
    drive0(0, 0, 0, 0, 0);
    @(negedge CLK);
    exp_d = (q0.size() > 0) ? q0.pop_front() : 32'hxxxxxxxx;
    checks++; if ({RVALID0, RVALID1} !== 2'b10 || RDATA !== exp_d) begin errors++; $display("FAIL rr_last: got rv=%b rd=%h want rv=10 rd=%h", {RVALID0, RVALID1}, RDATA, exp_d); end
    step();
  endtask

  task automatic test_out_of_range();
    drive0(1, 0, 32'h100, 0, 0);
    @(negedge CLK);
    checks++; if ({GNT0, M_WE} !== 2'b10) begin errors++; $display("FAIL oor_gnt: got %b want 10", {GNT0, M_WE}); end
    step();
    drive0(1, 1, 32'h104, 32'hFF, 4'b0001);
    @(negedge CLK);
    checks++; if ({ERR, RVALID0} !== 2'b11 || RDATA !== 32'h0) begin errors++; $display("FAIL oor_ld_resp: got err/rv=%b rd=%h want 11 rd=0", {ERR, RVALID0}, RDATA); end
    checks++; if ({GNT0, M_WE} !== 2'b10) begin errors++; $display("FAIL oor_st_gnt: got %b want 10", {GNT0, M_WE}); end
    step();
    drive0(1, 0, 32'hFC, 0, 0);
    q0.push_back(32'h12345678);
    @(negedge CLK);
    checks++; if ({ERR, RVALID0} !== 2'b10) begin errors++; $display("FAIL oor_st_resp: got %b want 10", {ERR, RVALID0}); end
    checks++; if (GNT0 !== 1'b1) begin errors++; $display("FAIL top_gnt: got %b want 1", GNT0); end
    step();
    drive0(0, 0, 0, 0, 0);
    @(negedge CLK);
    exp_d = (q0.size() > 0) ? q0.pop_front() : 32'hxxxxxxxx;
    checks++; if ({ERR, RVALID0} !== 2'b01 || RDATA !== exp_d) begin errors++; $display("FAIL top_resp: got err/rv=%b rd=%h want 01 rd=%h", {ERR, RVALID0}, RDATA, exp_d); end
    step();
  endtask

  task automatic test_reset_in_rmw();
    drive0(1, 1, 32'h30, 32'hFFFFFFFF, 4'b0011);
    @(negedge CLK);
    checks++; if ({GNT0, M_WE} !== 2'b00) begin errors++; $display("FAIL rrmw_c1: got %b want 00", {GNT0, M_WE}); end
    step();
    RST = 1'b1;
    @(negedge CLK);
    checks++; if ({GNT0, M_WE} !== 2'b00) begin errors++; $display("FAIL rrmw_rst: got %b want 00", {GNT0, M_WE}); end
    step();
    RST = 1'b0;
    drive0(0, 0, 0, 0, 0);
    @(negedge CLK);
    checks++; if (mem[12] !== 32'h55667788) begin errors++; $display("FAIL rrmw_mem: got %h want 55667788", mem[12]); end
    checks++; if ({GNT0, GNT1, M_WE, RVALID0, ERR} !== 5'b0) begin errors++; $display("FAIL rrmw_out: got %b want 00000", {GNT0, GNT1, M_WE, RVALID0, ERR}); end
    checks++; if (RDATA !== 32'h0 || M_A !== 32'h0) begin errors++; $display("FAIL rrmw_data: got rd=%h a=%h want 0", RDATA, M_A); end
    step();
    drive0(1, 0, 32'h4, 0, 0);
    drive1(1, 0, 32'h8, 0, 0);
    @(negedge CLK);
    checks++; if ({GNT0, GNT1} !== 2'b10) begin errors++; $display("FAIL rrmw_ptr: got %b want 10", {GNT0, GNT1}); end
    step();
    drive0(0, 0, 0, 0, 0);
    @(negedge CLK);
    checks++; if ({GNT0, GNT1} !== 2'b01) begin errors++; $display("FAIL rrmw_ptr2: got %b want 01", {GNT0, GNT1}); end
    step();
    drive1(0, 0, 0, 0, 0);
    step();
  endtask

  initial begin
    test_reset();
    test_full_store_load();
    test_rmw();
    test_rmw_contention();
    test_contention();
    test_out_of_range();
    test_reset_in_rmw();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port, word-addressed data memory (combinational read, write on clock edge).
- Port 0 is the core load/store path; port 1 is the debug/DMA loader.
- Grants one access per slot using round-robin arbitration.
- Converts byte-enabled stores into a native full-word write, or into a read-modify-write sequence when the byte mask is partial.

Parameters:
- DEPTH, 64, number of 32-bit words in the attached memory; legal byte addresses are 0 to DEPTH*4-1.
- AW, 32, byte-address width of requester and memory address ports.

Ports:
- CLK  input  1  clock.
- RST  input  1  synchronous reset, active-high.
- REQ0, REQ1  input  1  request valid, held until the matching GNT.
- WR0, WR1  input  1  1 = store, 0 = load.
- ADDR0, ADDR1  input  AW  byte address; bits [1:0] are ignored.
- WDATA0, WDATA1  input  32  store data, lane-aligned.
- BE0, BE1  input  4  byte enables for stores; ignored for loads.
- GNT0, GNT1  output  1  one-cycle pulse; the access completes in this cycle.
- RVALID0, RVALID1  output  1  registered pulse, one cycle after GNT of a load.
- RDATA  output  32  registered load data, shared by both ports and qualified by RVALID0/RVALID1.
- ERR  output  1  registered pulse, one cycle after GNT of an out-of-range access.
- M_A  output  AW  memory address.
- M_WD  output  32  memory write data.
- M_WE  output  1  memory write enable.
- M_RD  input  32  memory read data (combinational from M_A).

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high, on RST. All state updates on posedge CLK.
- Reset values:
  - FSM = IDLE; last-grant pointer = 1, so port 0 wins first contention.
  - RVALID0/1 = 0, ERR = 0, RDATA = 0, held merge register = 0.
  - Combinational outputs while idle with no request: GNT0/1 = 0, M_WE = 0, M_A = 0, M_WD = 0.
- Arbitration (IDLE only):
  - Single request: select it.
  - Both requesting: select the port not granted last.
  - Pointer updates only on a GNT.
- FSM states: IDLE, RMW_WR.
- IDLE, load: M_A = selected ADDR; GNTx = 1 in the same cycle; RDATA <= M_RD; RVALIDx = 1 next cycle. Load latency is 1 cycle from GNT.
- IDLE, store with BE = 4'hF: M_A = ADDR, M_WD = WDATA, M_WE = 1, GNTx = 1 in the same cycle.
- IDLE, store with BE = 0: GNTx = 1, M_WE = 0; no memory change.
- IDLE, store with partial BE:
  - Cycle 1: drive M_A; register merged = per byte, BE[i] ? WDATA byte i : M_RD byte i.
  - Latch the word address and the owner port; M_WE = 0, no GNT; go to RMW_WR.
- RMW_WR:
  - M_A = latched address, M_WD = merged, M_WE = 1.
  - GNT of the owner port = 1; return to IDLE.
  - The other port's request waits; no arbitration in this state.
- Throughput: a new access may be granted in the cycle immediately after a GNT.
- Out-of-range (ADDR[AW-1:2] >= DEPTH):
  - GNTx = 1 in IDLE; M_WE = 0 and no RMW.
  - ERR = 1 next cycle.
  - For a load, also RVALIDx = 1 next cycle with RDATA = 0.
- Exclusivity: at most one of GNT0/GNT1 is high in any cycle. At most one of RVALID0/RVALID1 is high in any cycle.
- Reset in RMW_WR: no write occurs that cycle, and the FSM returns to IDLE. The requester re-issues.
- Request dropped before GNT: protocol violation; behaviour is undefined. Cover with an assertion.

Decomposition:
- Package dmem_arb_pkg:
  - FSM state encoding (IDLE, RMW_WR).
  - Port index constants P_CORE = 0, P_DBG = 1.
  - BE_FULL = 4'hF.
- Sub-module byte_merge: combinational 4-lane select, (old, new, be) -> merged word. It is reused by the core's load/store unit.

Test Plan:
- Port 0 stores 0xDEADBEEF at 0x10 with BE = F, then loads 0x10:
  - Store: GNT0 and M_WE in the same cycle.
  - Load: GNT0, then RVALID0 with RDATA = 0xDEADBEEF one cycle later.
- RMW path: word 0x20 = 0x11223344; port 1 stores WDATA = 0x000000AA with BE = 0001.
  - Expected: no GNT in cycle 1; GNT1 and M_WE in cycle 2.
  - Memory word becomes 0x112233AA.
- Contention from reset: REQ0 = REQ1 = 1, both loads, continuously.
  - Grants go GNT0, GNT1, GNT0, GNT1 in consecutive cycles.
  - There is never a cycle with both grants high.
- Contention during RMW: port 0 partial store starts, and port 1 raises a load in cycle 1.
  - GNT1 is held off until the cycle after port 0's GNT.
  - Port 1's load then returns the merged word.
- Out-of-range: port 0 loads address 0x100 with DEPTH = 64.
  - GNT0 is granted; next cycle ERR = 1, RVALID0 = 1, RDATA = 0.
  - M_WE stays 0 throughout.
- RST asserted in RMW_WR during a partial store to 0x30:
  - Word 0x30 is unchanged; all outputs take their reset values the next cycle.
  - The pointer favours port 0 afterwards.
